// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run sequencer.
package cpu_run_pkg;

  // Default width of the cycle counter and run limit.
  localparam int unsigned CycWDefault = 16;

  // Largest number of cores one sequencer may drive.
  localparam int unsigned MaxNCpu = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StDelay,
    StStart,
    StRun,
    StDone
  } run_state_e;

endpackage

// File: rtl/run_start_stagger.sv
// Staggered start-pulse generator: walks a counter through the START window and
// decodes one single-cycle pulse per core at slot i*STAGGER.
module run_start_stagger #(
  parameter int unsigned N_CPU   = 1,
  parameter int unsigned STAGGER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [N_CPU-1:0] start_o,
  output logic [N_CPU-1:0] armed_o,
  output logic             last_o
);

  localparam int unsigned Len  = (N_CPU - 1) * STAGGER + 1;
  localparam int unsigned CntW = (Len > 1) ? $clog2(Len) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Len - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Advance through the START window; park at zero otherwise and after the last slot.
  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LastIdx)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Slot counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pulse in a core's own slot; armed once that slot lies strictly in the past.
  always_comb begin
    start_o = '0;
    armed_o = '0;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      start_o[i] = en_i && (cnt_q == CntW'(i * STAGGER));
      armed_o[i] = en_i && (cnt_q > CntW'(i * STAGGER));
    end
  end

  assign last_o = en_i && (cnt_q == LastIdx);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run controller for one or more CPU cores: holds them in reset, releases them,
// issues staggered start pulses, counts cycles and ends the run on halt or limit.
module cpu_run_sequencer
  import cpu_run_pkg::*;
#(
  parameter int unsigned N_CPU       = 1,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned START_DELAY = 1,
  parameter int unsigned STAGGER     = 0,
  parameter int unsigned CYC_W       = CycWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [CYC_W-1:0] max_cycles,
  input  logic [N_CPU-1:0] halted,
  output logic             cpu_rst,
  output logic [N_CPU-1:0] cpu_start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

  if (N_CPU == 0 || N_CPU > MaxNCpu || RST_CYCLES == 0) begin : g_param_check
    $error("cpu_run_sequencer: parameter out of range");
  end

  // One down-counter serves both RESET and DELAY; it is reloaded on entry.
  localparam int unsigned DlyMax = (RST_CYCLES > START_DELAY) ? RST_CYCLES : START_DELAY;
  localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax) : 1;
  localparam logic [DlyW-1:0] RstLoad = DlyW'(RST_CYCLES - 1);
  localparam logic [DlyW-1:0] DlyLoad = (START_DELAY > 0) ? DlyW'(START_DELAY - 1) : '0;

  run_state_e       state_q, state_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [N_CPU-1:0] sticky_q, sticky_d, halt_all;
  logic             timeout_q, timeout_d;

  logic             stg_en, stg_last;
  logic [N_CPU-1:0] stg_start, stg_armed;

  assign stg_en = (state_q == StStart);

  run_start_stagger #(
    .N_CPU  (N_CPU),
    .STAGGER(STAGGER)
  ) u_stagger (
    .clk    (clk),
    .rst    (rst),
    .en_i   (stg_en),
    .start_o(stg_start),
    .armed_o(stg_armed),
    .last_o (stg_last)
  );

  // Saturating increment; the counter never wraps.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CYC_W'(1);
  // Includes this cycle's halts so a final halt ends the run without extra latency.
  assign halt_all = sticky_q | halted;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d   = StReset;
          dly_d     = RstLoad;
          cnt_d     = '0;
          sticky_d  = '0;
          timeout_d = 1'b0;
        end
      end
      StReset: begin
        if (dly_q == '0) begin
          if (START_DELAY == 0) begin
            state_d = StStart;
          end else begin
            state_d = StDelay;
            dly_d   = DlyLoad;
          end
        end else begin
          dly_d = dly_q - DlyW'(1);
        end
      end
      StDelay: begin
        if (dly_q == '0) begin
          state_d = StStart;
        end else begin
          dly_d = dly_q - DlyW'(1);
        end
      end
      StStart: begin
        // Only cores whose pulse is already behind them may record a halt.
        sticky_d = sticky_q | (halted & stg_armed);
        cnt_d    = cnt_inc;
        if (stg_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        sticky_d = halt_all;
        // The exit edge does not count, so the final value is the one seen here.
        if (&halt_all) begin
          state_d   = StDone;
          timeout_d = 1'b0;
        end else if ((max_cycles != '0) && (cnt_q >= max_cycles)) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        if (!go) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: phase counter, cycle counter, halt mask, timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      timeout_q <= timeout_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    cpu_rst = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: cpu_rst = 1'b1;
      StReset: begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
      end
      StDelay, StStart, StRun: busy = 1'b1;
      StDone: done = 1'b1;
      default: cpu_rst = 1'b1;
    endcase
  end

  assign cpu_start   = stg_start;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: a timeline model of a 4-core staggered instance checked every
// cycle, directed runs with literal expectations, and a small 2-core instance with no
// start delay and no stagger.
module tb_cpu_run_sequencer;

  localparam int NC   = 4;
  localparam int RC   = 2;
  localparam int SD   = 1;
  localparam int STG  = 3;
  localparam int CW   = 16;
  localparam int SOff = RC + SD + 1;       // rel cycle of the first start pulse
  localparam int SLen = (NC - 1) * STG + 1;  // length of the start window

  localparam int PIdle = 0;
  localparam int PAct  = 1;
  localparam int PDone = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go  = 1'b0;
  logic [CW-1:0] max_cycles = '0;
  logic [NC-1:0] halted = '0;
  logic          cpu_rst, busy, done, timeout;
  logic [NC-1:0] cpu_start;
  logic [CW-1:0] cycle_count;

  logic       z_go = 1'b0;
  logic [7:0] z_max = '0;
  logic [1:0] z_halt = '0;
  logic       z_cpu_rst, z_busy, z_done, z_timeout;
  logic [1:0] z_start;
  logic [7:0] z_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  cpu_run_sequencer #(
    .N_CPU      (NC),
    .RST_CYCLES (RC),
    .START_DELAY(SD),
    .STAGGER    (STG),
    .CYC_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .max_cycles (max_cycles),
    .halted     (halted),
    .cpu_rst    (cpu_rst),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  cpu_run_sequencer #(
    .N_CPU      (2),
    .RST_CYCLES (1),
    .START_DELAY(0),
    .STAGGER    (0),
    .CYC_W      (8)
  ) dut_z (
    .clk        (clk),
    .rst        (rst),
    .go         (z_go),
    .max_cycles (z_max),
    .halted     (z_halt),
    .cpu_rst    (z_cpu_rst),
    .cpu_start  (z_start),
    .busy       (z_busy),
    .done       (z_done),
    .timeout    (z_timeout),
    .cycle_count(z_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Timeline model: m_rel counts cycles since the accepted go edge (rel 1 = first RESET cycle).
  int            m_phase = PIdle;
  int            m_rel = 0;
  int            m_hold = 0;
  bit            m_to = 1'b0;
  logic [NC-1:0] m_seen = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= PIdle;
      m_rel   <= 0;
      m_hold  <= 0;
      m_to    <= 1'b0;
      m_seen  <= '0;
    end else begin
      case (m_phase)
        PIdle: begin
          if (go) begin
            m_phase <= PAct;
            m_rel   <= 1;
            m_seen  <= '0;
            m_hold  <= 0;
            m_to    <= 1'b0;
          end
        end
        PAct: begin : act
          logic [NC-1:0] seen;
          int            c;
          bit            running;
          seen = m_seen;
          for (int i = 0; i < NC; i++) begin
            if (halted[i] && (m_rel > SOff + i * STG)) seen[i] = 1'b1;
          end
          m_seen  <= seen;
          c       = sat(m_rel - SOff);
          running = (m_rel >= SOff + SLen);
          if (running && (&seen)) begin
            m_phase <= PDone;
            m_hold  <= c;
            m_to    <= 1'b0;
          end else if (running && (max_cycles != 0) && (c >= int'(max_cycles))) begin
            m_phase <= PDone;
            m_hold  <= c;
            m_to    <= 1'b1;
          end else begin
            m_rel <= m_rel + 1;
          end
        end
        PDone: if (!go) m_phase <= PIdle;
        default: m_phase <= PIdle;
      endcase
    end
  end

  // Compare the 4-core instance against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin : cmp
      logic          e_rst, e_busy, e_done, e_to;
      logic [NC-1:0] e_start;
      int            e_cnt;
      e_start = '0;
      case (m_phase)
        PAct: begin
          e_rst  = (m_rel <= RC);
          e_busy = 1'b1;
          e_done = 1'b0;
          e_to   = 1'b0;
          e_cnt  = (m_rel >= SOff) ? sat(m_rel - SOff) : 0;
          for (int i = 0; i < NC; i++) begin
            if (m_rel - SOff == i * STG) e_start[i] = 1'b1;
          end
        end
        PDone: begin
          e_rst  = 1'b0;
          e_busy = 1'b0;
          e_done = 1'b1;
          e_to   = m_to;
          e_cnt  = m_hold;
        end
        default: begin
          e_rst  = 1'b1;
          e_busy = 1'b0;
          e_done = 1'b0;
          e_to   = m_to;
          e_cnt  = m_hold;
        end
      endcase
      check("model cpu_rst", 32'(cpu_rst), 32'(e_rst));
      check("model busy", 32'(busy), 32'(e_busy));
      check("model done", 32'(done), 32'(e_done));
      check("model timeout", 32'(timeout), 32'(e_to));
      check("model cpu_start", 32'(cpu_start), 32'(e_start));
      check("model cycle_count", 32'(cycle_count), 32'(e_cnt));
    end
  end

  task automatic wait_count(input int v, input int budget);
    int k;
    k = 0;
    while ((int'(cycle_count) != v) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check("wait_count", 32'(cycle_count), 32'(v));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cpu_rst"}, 32'(cpu_rst), 32'(1));
    check({tag, " cpu_start"}, 32'(cpu_start), 32'(0));
    check({tag, " busy"}, 32'(busy), 32'(0));
    check({tag, " done"}, 32'(done), 32'(0));
    check({tag, " timeout"}, 32'(timeout), 32'(0));
    check({tag, " cycle_count"}, 32'(cycle_count), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    #2 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Run A: staggered starts, pre-pulse halt ignored, staggered halts in RUN.
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);  // rel 1
    go = 1'b0;
    check("A rel1 cpu_rst", 32'(cpu_rst), 32'(1));
    check("A rel1 busy", 32'(busy), 32'(1));
    @(negedge clk);  // rel 2
    check("A rel2 cpu_rst", 32'(cpu_rst), 32'(1));
    @(negedge clk);  // rel 3
    check("A rel3 cpu_rst", 32'(cpu_rst), 32'(0));
    check("A rel3 cpu_start", 32'(cpu_start), 32'(0));
    @(negedge clk);  // rel 4
    check("A rel4 cpu_start", 32'(cpu_start), 32'h1);
    check("A rel4 count", 32'(cycle_count), 32'(0));
    @(negedge clk);  // rel 5
    check("A rel5 count", 32'(cycle_count), 32'(1));
    @(negedge clk);  // rel 6: core 3 not started yet
    halted = 4'b1000;
    @(negedge clk);  // rel 7
    halted = 4'b0000;
    check("A rel7 cpu_start", 32'(cpu_start), 32'h2);
    repeat (6) @(negedge clk);  // rel 13
    check("A rel13 cpu_start", 32'(cpu_start), 32'h8);
    check("A rel13 count", 32'(cycle_count), 32'(9));
    wait_count(12, 50);
    halted = 4'b0011;
    @(negedge clk);
    halted = 4'b0000;
    wait_count(15, 50);
    halted = 4'b0100;
    @(negedge clk);
    halted = 4'b0000;
    check("A partial halt done", 32'(done), 32'(0));
    wait_count(20, 50);
    halted = 4'b1000;
    @(negedge clk);
    halted = 4'b0000;
    check("A done", 32'(done), 32'(1));
    check("A final count", 32'(cycle_count), 32'(20));
    check("A timeout", 32'(timeout), 32'(0));
    check("A done cpu_rst", 32'(cpu_rst), 32'(0));
    @(negedge clk);
    check("A idle cpu_rst", 32'(cpu_rst), 32'(1));
    check("A idle count held", 32'(cycle_count), 32'(20));

    // Run B: limit reached; go held high keeps DONE.
    max_cycles = 16'd20;
    go = 1'b1;
    @(negedge clk);
    wait_count(20, 100);
    @(negedge clk);
    check("B done", 32'(done), 32'(1));
    check("B timeout", 32'(timeout), 32'(1));
    check("B final count", 32'(cycle_count), 32'(20));
    repeat (5) @(negedge clk);
    check("B hold done", 32'(done), 32'(1));
    check("B hold busy", 32'(busy), 32'(0));
    go = 1'b0;
    @(negedge clk);
    check("B idle done", 32'(done), 32'(0));
    check("B idle timeout held", 32'(timeout), 32'(1));

    // Run D: last core halts on the same cycle the limit is reached.
    max_cycles = 16'd25;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_count(10, 50);
    halted = 4'b0111;
    wait_count(25, 50);
    halted = 4'b1111;
    @(negedge clk);
    halted = 4'b0000;
    check("D done", 32'(done), 32'(1));
    check("D timeout", 32'(timeout), 32'(0));
    check("D final count", 32'(cycle_count), 32'(25));
    @(negedge clk);

    // Run C: pre-pulse halt of core 3 never counts, go toggled mid-run is ignored.
    max_cycles = 16'd30;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_count(2, 20);
    halted = 4'b1000;
    @(negedge clk);
    halted = 4'b0000;
    wait_count(12, 50);
    halted = 4'b0111;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_count(30, 50);
    @(negedge clk);
    halted = 4'b0000;
    check("C done", 32'(done), 32'(1));
    check("C timeout", 32'(timeout), 32'(1));
    check("C final count", 32'(cycle_count), 32'(30));
    #2 rst = 1'b1;
    #1 check_reset_values("C rst in done");
    @(negedge clk);
    rst = 1'b0;

    // Run E: reset during RUN.
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_count(5, 50);
    check("E busy before rst", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1 check_reset_values("E rst in run");
    @(negedge clk);
    rst = 1'b0;

    // Run F: unlimited run saturates the counter, then halts.
    max_cycles = '0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_count(65535, 70000);
    repeat (3) @(negedge clk);
    check("F saturated count", 32'(cycle_count), 32'hFFFF);
    check("F still busy", 32'(busy), 32'(1));
    halted = 4'b1111;
    @(negedge clk);
    halted = 4'b0000;
    check("F done", 32'(done), 32'(1));
    check("F final count", 32'(cycle_count), 32'hFFFF);
    check("F timeout", 32'(timeout), 32'(0));
    @(negedge clk);

    // Small instance: one reset cycle, no delay, both cores pulse together.
    z_max = 8'd5;
    z_go  = 1'b1;
    @(negedge clk);  // rel 1
    z_go = 1'b0;
    check("Z rel1 cpu_rst", 32'(z_cpu_rst), 32'(1));
    check("Z rel1 busy", 32'(z_busy), 32'(1));
    check("Z rel1 start", 32'(z_start), 32'(0));
    @(negedge clk);  // rel 2
    check("Z rel2 start", 32'(z_start), 32'h3);
    check("Z rel2 cpu_rst", 32'(z_cpu_rst), 32'(0));
    check("Z rel2 count", 32'(z_count), 32'(0));
    @(negedge clk);  // rel 3
    check("Z rel3 start", 32'(z_start), 32'(0));
    check("Z rel3 count", 32'(z_count), 32'(1));
    repeat (5) @(negedge clk);  // rel 8
    check("Z done", 32'(z_done), 32'(1));
    check("Z timeout", 32'(z_timeout), 32'(1));
    check("Z final count", 32'(z_count), 32'(5));
    @(negedge clk);
    z_max = '0;
    z_go  = 1'b1;
    @(negedge clk);
    z_go = 1'b0;
    repeat (300) @(negedge clk);
    check("Z saturated count", 32'(z_count), 32'hFF);
    check("Z still busy", 32'(z_busy), 32'(1));
    z_halt = 2'b11;
    @(negedge clk);
    z_halt = 2'b00;
    check("Z halt done", 32'(z_done), 32'(1));
    check("Z halt timeout", 32'(z_timeout), 32'(0));
    check("Z halt count", 32'(z_count), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
